serial_adder: RTL and testbench

Bit-serial adder that reuses one `full_adder` instance over WIDTH clock cycles to add two WIDTH-bit operands. It is the sequential stage built around the full adder: it loads operands, presents one bit pair plus a stored carry per cycle, and collects the sum bits. It suits area-constrained datapaths where the ripple-carry adder's parallel cell count is too costly. A start/busy/done handshake delivers the result to downstream logic.

---
 rtl/serial_adder.sv | 126 ++++++++++++
 tb/tb_serial_adder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder reusing one full_adder cell over WIDTH cycles
// Operands shift out LSB-first; sum bits shift in MSB-side so the result lands aligned.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, s_sr, s_nxt;
    logic             c_q;
    logic [CW-1:0]    cnt;
    logic             fa_sum, fa_cout;
    logic             accept, last;

    full_adder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (c_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // A one-bit result register has no upper bits to shift down.
    generate
        if (WIDTH == 1) begin : g_narrow
            assign s_nxt = fa_sum;
        end else begin : g_wide
            assign s_nxt = {fa_sum, s_sr[WIDTH-1:1]};
        end
    endgenerate

    assign last = (cnt == LAST);

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr <= '0;
            b_sr <= '0;
            s_sr <= '0;
            c_q  <= 1'b0;
            cnt  <= '0;
            sum  <= '0;
            cout <= 1'b0;
        end else if (accept) begin
            a_sr <= a;
            b_sr <= b;
            c_q  <= cin;
            cnt  <= '0;
        end else if (state == SHIFT) begin
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            s_sr <= s_nxt;
            c_q  <= fa_cout;
            cnt  <= cnt + CW'(1);
            // Publish on the final bit so sum/cout stay stable through the next SHIFT.
            if (last) begin
                sum  <= s_nxt;
                cout <= fa_cout;
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed and exhaustive checks of serial_adder at WIDTH=4 and WIDTH=1

module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst;
    logic       start4, cin4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;
    logic       start1, cin1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;

    int errors = 0;
    int checks = 0;
    logic [3:0] prev_s4;
    logic       prev_c4;
    logic [0:0] prev_s1;
    logic       prev_c1;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] s;
        logic       co;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Starts an add on dut4 and checks the exact busy/done timeline and result hold.
    task automatic run_op4(input logic [3:0] ta, input logic [3:0] tb, input logic tc,
                           input logic [3:0] es, input logic ec);
        @(negedge clk);
        a4 = ta; b4 = tb; cin4 = tc; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0; a4 = ~ta; b4 = ~tb; cin4 = ~tc;
        for (int i = 0; i < 4; i++) begin
            check("w4_busy", busy4, 1'b1);
            check("w4_done_early", done4, 1'b0);
            check("w4_sum_hold", sum4, prev_s4);
            check("w4_cout_hold", cout4, prev_c4);
            @(negedge clk);
        end
        check("w4_done", done4, 1'b1);
        check("w4_busy_in_done", busy4, 1'b0);
        check("w4_sum", sum4, es);
        check("w4_cout", cout4, ec);
        prev_s4 = es; prev_c4 = ec;
        @(negedge clk);
        check("w4_done_pulse", done4, 1'b0);
        check("w4_idle_busy", busy4, 1'b0);
        check("w4_sum_after", sum4, es);
    endtask

    task automatic run_op1(input logic ta, input logic tb, input logic tc,
                           input logic es, input logic ec);
        @(negedge clk);
        a1 = ta; b1 = tb; cin1 = tc; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; a1 = ~ta; b1 = ~tb; cin1 = ~tc;
        check("w1_busy", busy1, 1'b1);
        check("w1_done_early", done1, 1'b0);
        check("w1_sum_hold", sum1, prev_s1);
        check("w1_cout_hold", cout1, prev_c1);
        @(negedge clk);
        check("w1_done", done1, 1'b1);
        check("w1_sum", sum1, es);
        check("w1_cout", cout1, ec);
        prev_s1 = es; prev_c1 = ec;
        @(negedge clk);
        check("w1_done_pulse", done1, 1'b0);
        check("w1_idle_busy", busy1, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[6];
        logic [4:0] exp4;
        logic [1:0] exp1;

        vecs[0] = '{a: 4'b0101, b: 4'b0011, cin: 1'b0, s: 4'b1000, co: 1'b0};
        vecs[1] = '{a: 4'b1111, b: 4'b0001, cin: 1'b0, s: 4'b0000, co: 1'b1};
        vecs[2] = '{a: 4'b1111, b: 4'b1111, cin: 1'b1, s: 4'b1111, co: 1'b1};
        vecs[3] = '{a: 4'b0000, b: 4'b0000, cin: 1'b0, s: 4'b0000, co: 1'b0};
        vecs[4] = '{a: 4'b1010, b: 4'b0101, cin: 1'b1, s: 4'b0000, co: 1'b1};
        vecs[5] = '{a: 4'b0111, b: 4'b0001, cin: 1'b0, s: 4'b1000, co: 1'b0};

        rst = 1'b1;
        start4 = 1'b1; a4 = 4'hf; b4 = 4'hf; cin4 = 1'b1;
        start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        repeat (3) @(negedge clk);
        start4 = 1'b0; start1 = 1'b0;
        @(negedge clk);
        check("rst_busy4", busy4, 1'b0);
        check("rst_done4", done4, 1'b0);
        check("rst_sum4", sum4, 4'h0);
        check("rst_cout4", cout4, 1'b0);
        check("rst_busy1", busy1, 1'b0);
        check("rst_sum1", sum1, 1'b0);
        rst = 1'b0;
        prev_s4 = 4'h0; prev_c4 = 1'b0;
        prev_s1 = 1'b0; prev_c1 = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_op4(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].co);
        end

        // Second start during SHIFT is ignored; operand changes have no effect.
        @(negedge clk);
        a4 = 4'b0001; b4 = 4'b0001; cin4 = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        a4 = 4'b1111; b4 = 4'b1111; cin4 = 1'b1; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0; a4 = 4'b0111; b4 = 4'b1001;
        @(negedge clk);
        check("ign_busy", busy4, 1'b1);
        @(negedge clk);
        check("ign_done", done4, 1'b1);
        check("ign_sum", sum4, 4'b0010);
        check("ign_cout", cout4, 1'b0);
        @(negedge clk);
        check("ign_no_restart", busy4, 1'b0);
        check("ign_done_pulse", done4, 1'b0);
        prev_s4 = 4'b0010; prev_c4 = 1'b0;

        // Held start: back-to-back results every WIDTH+1 cycles.
        @(negedge clk);
        a4 = 4'b0011; b4 = 4'b0100; cin4 = 1'b1; start4 = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            check("b2b_done", done4, (i % 5) == 0);
            check("b2b_busy", busy4, (i % 5) != 0);
            if (done4) begin
                check("b2b_sum", sum4, 4'b1000);
                check("b2b_cout", cout4, 1'b0);
            end
            if (i == 15) start4 = 1'b0;
        end
        @(negedge clk);
        check("b2b_stop_busy", busy4, 1'b0);
        check("b2b_stop_done", done4, 1'b0);

        // Reset on the third SHIFT cycle aborts the add and clears the result.
        @(negedge clk);
        a4 = 4'b0101; b4 = 4'b0011; cin4 = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy4, 1'b0);
        check("abort_done", done4, 1'b0);
        check("abort_sum", sum4, 4'h0);
        check("abort_cout", cout4, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_no_done", done4, 1'b0);
        end
        prev_s4 = 4'h0; prev_c4 = 1'b0;
        run_op4(4'b0110, 4'b0111, 1'b0, 4'b1101, 1'b0);

        // Exhaustive sweeps.
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = i[8:0];
            exp4 = {1'b0, v[3:0]} + {1'b0, v[7:4]} + {4'b0, v[8]};
            run_op4(v[3:0], v[7:4], v[8], exp4[3:0], exp4[4]);
        end
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = i[2:0];
            exp1 = {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
            run_op1(v[0], v[1], v[2], exp1[0], exp1[1]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
